load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  AWIDTH, 32, address width.
  DWIDTH, 32, data width (fixed at 32).
  TIMEOUT, 15, max cycles waiting for mem_data_vld_i.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  clock, all state on rising edge.
  rst  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
  req_valid_i  in  1  core request valid.
  req_ready_o  out  1  unit can accept a request.
  req_we_i  in  1  1=store, 0=load.
  req_funct3_i  in  3  RV32I size/sign code.
  req_addr_i  in  AWIDTH  byte address (absolute, incl. 0x01000000 base).
  req_wdata_i  in  DWIDTH  store data, right-aligned.
  resp_valid_o  out  1  one-cycle response pulse.
  resp_rdata_o  out  DWIDTH  load result, extended.
  resp_err_o  out  1  misaligned, illegal or timeout.
  mem_addr_o  out  AWIDTH  word-aligned memory address.
  mem_data_o  out  DWIDTH  memory write data.
  mem_read_en_o  out  1  memory read enable.
  mem_write_en_o  out  1  memory write enable (full word).
  mem_data_i  in  DWIDTH  memory read data, little-endian.
  mem_data_vld_i  in  1  memory read data valid (combinational).

Function
REQ-003 The FSM SHALL have states IDLE, RD, RMW_RD, WR, RESP; req_ready_o=1 only in IDLE.
REQ-004 A request SHALL be accepted on a rising edge with req_valid_i&&req_ready_o; addr, we, funct3 and wdata SHALL be latched.
REQ-005 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; any other code is illegal.
REQ-006 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; byte never misaligned.
REQ-007 From IDLE on accept: illegal or misaligned -> RESP with err=1; load -> RD; SW -> WR; SB/SH -> RMW_RD.
REQ-008 In RD/RMW_RD: mem_read_en_o=1, mem_addr_o={addr[AWIDTH-1:2],2'b00}; on mem_data_vld_i=1 the word SHALL be captured; RD -> RESP, RMW_RD -> WR.
REQ-009 Load extraction: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-010 RMW merge: only the addressed byte/halfword lane SHALL be replaced by req_wdata_i[7:0]/[15:0]; other lanes keep read data.
REQ-011 In WR: mem_write_en_o=1 for exactly one cycle, aligned mem_addr_o, merged (or full SW) data on mem_data_o; then RESP.
REQ-012 In RESP: resp_valid_o=1 for exactly one cycle; resp_rdata_o=extended load data for good loads, 0 for stores and errors; then IDLE.
REQ-013 mem_read_en_o and mem_write_en_o SHALL never be high together, and SHALL be 0 in IDLE and RESP.
REQ-014 Latency accept-to-resp_valid: load 2 cycles (vld immediate), SW 2, SB/SH 3, error 1.
REQ-015 A wait counter SHALL count cycles in RD/RMW_RD with vld=0; at TIMEOUT the FSM SHALL go to RESP with err=1 and no write.
REQ-016 No new request SHALL be accepted in the cycle resp_valid_o=1; back-to-back accept is allowed in the following cycle.

Reset
REQ-017 rst=0 SHALL asynchronously force IDLE, counter 0, all latched regs 0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_read_en_o=0, mem_write_en_o=0, mem_addr_o=0, mem_data_o=0.
REQ-018 Reset mid-operation SHALL abandon the request with no response; req_ready_o=1 on the first edge after release.

Verification (mem word 0x01000010 = 0x8899AABB)
REQ-019 LB 0x01000011 -> resp_rdata 0xFFFFFFAA, err=0, resp_valid 2 cycles after accept.
REQ-020 LHU 0x01000012 -> 0x00008899; LH same -> 0xFFFF8899.
REQ-021 SB 0x01000013 wdata 0x12345677 -> one write, addr 0x01000010, data 0x7799AABB; resp 3 cycles after accept.
REQ-022 LW 0x01000012 -> err=1, rdata 0, no mem enable asserted, resp 1 cycle after accept.
REQ-023 rst=0 during WR -> mem_write_en_o drops immediately, no resp_valid, memory word unchanged.
REQ-024 LW with mem_data_vld_i held 0 -> err=1 after TIMEOUT=15 wait cycles, mem_write_en_o never asserted.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with byte/halfword read-modify-write
module load_store_unit #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DWIDTH-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  input  logic              mem_data_vld_i
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CW-1:0]       wait_cnt_q, wait_cnt_d;

  logic                req_legal;
  logic                req_misaligned;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;
  logic [DWIDTH-1:0]   load_data;
  logic [DWIDTH-1:0]   merge_data;
  logic [AWIDTH-1:0]   aligned_addr;

  assign aligned_addr = {addr_q[AWIDTH-1:2], 2'b00};

  // Unsigned variants exist only for loads; stores accept just B/H/W.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3_i)
      F3_B, F3_H, F3_W: req_legal = 1'b1;
      F3_BU, F3_HU:     req_legal = !req_we_i;
      default:          req_legal = 1'b0;
    endcase
  end

  assign req_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                          ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));

  always_comb begin
    lane_byte = rdata_q[7:0];
    case (addr_q[1:0])
      2'b00:   lane_byte = rdata_q[7:0];
      2'b01:   lane_byte = rdata_q[15:8];
      2'b10:   lane_byte = rdata_q[23:16];
      default: lane_byte = rdata_q[31:24];
    endcase
  end

  assign lane_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data = rdata_q;
    case (funct3_q)
      F3_B:    load_data = {{(DWIDTH-8){lane_byte[7]}}, lane_byte};
      F3_BU:   load_data = {{(DWIDTH-8){1'b0}}, lane_byte};
      F3_H:    load_data = {{(DWIDTH-16){lane_half[15]}}, lane_half};
      F3_HU:   load_data = {{(DWIDTH-16){1'b0}}, lane_half};
      default: load_data = rdata_q;
    endcase
  end

  // Sub-word stores overwrite only their lane of the word fetched in RMW_RD.
  always_comb begin
    merge_data = rdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'b00:   merge_data[7:0]   = wdata_q[7:0];
          2'b01:   merge_data[15:8]  = wdata_q[7:0];
          2'b10:   merge_data[23:16] = wdata_q[7:0];
          default: merge_data[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merge_data[31:16] = wdata_q[15:0];
        else           merge_data[15:0]  = wdata_q[15:0];
      end
      default: merge_data = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    we_d           = we_q;
    funct3_d       = funct3_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    wait_cnt_d     = wait_cnt_q;
    req_ready_o    = 1'b0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    resp_valid_o   = 1'b0;
    resp_err_o     = 1'b0;
    resp_rdata_o   = '0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d     = req_addr_i;
          we_d       = req_we_i;
          funct3_d   = req_funct3_i;
          wdata_d    = req_wdata_i;
          err_d      = 1'b0;
          wait_cnt_d = '0;
          if (!req_legal || req_misaligned) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!req_we_i) begin
            state_d = RD;
          end else if (req_funct3_i == F3_W) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end

      RD, RMW_RD: begin
        mem_read_en_o = 1'b1;
        mem_addr_o    = aligned_addr;
        if (mem_data_vld_i) begin
          rdata_d    = mem_data_i;
          wait_cnt_d = '0;
          state_d    = (state_q == RD) ? RESP : WR;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          // Abandon the access; a timed-out RMW must never reach WR.
          err_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end

      WR: begin
        mem_write_en_o = 1'b1;
        mem_addr_o     = aligned_addr;
        mem_data_o     = merge_data;
        state_d        = RESP;
      end

      RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        resp_rdata_o = (err_q || we_q) ? '0 : load_data;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [31:0] mem_data_i;
  logic        mem_data_vld_i;

  logic        vld_en;
  logic        load_mem;
  logic [31:0] mem [16];
  int          write_cnt;
  int          read_cycles;
  int          bad_overlap;
  int          bad_idle;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;

  int checks;
  int errors;

  load_store_unit #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .mem_read_en_o(mem_read_en_o),
    .mem_write_en_o(mem_write_en_o),
    .mem_data_i(mem_data_i),
    .mem_data_vld_i(mem_data_vld_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data_i     = mem[mem_addr_o[5:2]];
  assign mem_data_vld_i = mem_read_en_o & vld_en;

  initial begin
    write_cnt   = 0;
    read_cycles = 0;
    bad_overlap = 0;
    bad_idle    = 0;
    last_waddr  = '0;
    last_wdata  = '0;
  end

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
      mem[5] <= 32'h11223344;
      mem[7] <= 32'h55667788;
    end else if (mem_write_en_o) begin
      mem[mem_addr_o[5:2]] <= mem_data_o;
      write_cnt  <= write_cnt + 1;
      last_waddr <= mem_addr_o;
      last_wdata <= mem_data_o;
    end
  end

  always @(negedge clk) begin
    if (mem_read_en_o) read_cycles <= read_cycles + 1;
    if (mem_read_en_o && mem_write_en_o) bad_overlap <= bad_overlap + 1;
    if (rst && (req_ready_o || resp_valid_o) && (mem_read_en_o || mem_write_en_o))
      bad_idle <= bad_idle + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic rdy, output int lat,
                        output logic [31:0] rd, output logic er);
    @(negedge clk);
    rdy          = req_ready_o;
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    lat = -1;
    rd  = 'x;
    er  = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (resp_valid_o) begin
        lat = i;
        rd  = resp_rdata_o;
        er  = resp_err_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; load_mem = 1'b1; vld_en = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0; req_addr_i = '0; req_wdata_i = '0;
    repeat (3) @(negedge clk);
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid_o); end
    checks++; if (resp_err_o !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err_o); end
    checks++; if (resp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata_o); end
    checks++; if (mem_read_en_o !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b want 0", mem_read_en_o); end
    checks++; if (mem_write_en_o !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b want 0", mem_write_en_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
    checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL reset_mem_data: got %h want 0", mem_data_o); end
    rst = 1'b1; load_mem = 1'b0;
    @(negedge clk);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [10];
    logic [31:0] ad [10];
    logic [31:0] ex [10];
    logic        rdy, er;
    int          lat, wr0, rd0;
    logic [31:0] rd;
    f3 = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b000, 3'b001, 3'b100, 3'b000, 3'b001};
    ad = '{32'h01000011, 32'h01000011, 32'h01000012, 32'h01000012, 32'h01000010,
           32'h01000010, 32'h01000010, 32'h01000013, 32'h01000013, 32'h01000016};
    ex = '{32'hFFFFFFAA, 32'h000000AA, 32'h00008899, 32'hFFFF8899, 32'h8899AABB,
           32'hFFFFFFBB, 32'hFFFFAABB, 32'h00000088, 32'hFFFFFF88, 32'h00001122};
    wr0 = write_cnt; rd0 = read_cycles;
    for (int i = 0; i < 10; i++) begin
      do_req(1'b0, f3[i], ad[i], 32'hA5A5A5A5, rdy, lat, rd, er);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL load%0d_ready: got %b want 1", i, rdy); end
      checks++; if (lat != 2) begin errors++; $display("FAIL load%0d_latency: got %0d want 2", i, lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL load%0d_err: got %b want 0", i, er); end
      checks++; if (rd !== ex[i]) begin errors++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, ex[i]); end
    end
    checks++; if (write_cnt != wr0) begin errors++; $display("FAIL loads_no_write: got %0d writes want 0", write_cnt - wr0); end
    checks++; if (read_cycles - rd0 != 10) begin errors++; $display("FAIL loads_read_cycles: got %0d want 10", read_cycles - rd0); end
  endtask

  task automatic test_errors();
    logic        we [9];
    logic [2:0]  f3 [9];
    logic [31:0] ad [9];
    logic        rdy, er;
    int          lat, wr0, rd0;
    logic [31:0] rd, m4;
    we = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    f3 = '{3'b010, 3'b001, 3'b101, 3'b011, 3'b110, 3'b100, 3'b001, 3'b010, 3'b011};
    ad = '{32'h01000012, 32'h01000011, 32'h01000013, 32'h01000010, 32'h01000010,
           32'h01000010, 32'h01000011, 32'h01000012, 32'h01000010};
    wr0 = write_cnt; rd0 = read_cycles; m4 = mem[4];
    for (int i = 0; i < 9; i++) begin
      do_req(we[i], f3[i], ad[i], 32'hFFFFFFFF, rdy, lat, rd, er);
      checks++; if (lat != 1) begin errors++; $display("FAIL err%0d_latency: got %0d want 1", i, lat); end
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL err%0d_err: got %b want 1", i, er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err%0d_rdata: got %h want 0", i, rd); end
    end
    checks++; if (write_cnt != wr0) begin errors++; $display("FAIL errors_no_write: got %0d writes want 0", write_cnt - wr0); end
    checks++; if (read_cycles != rd0) begin errors++; $display("FAIL errors_no_read: got %0d read cycles want 0", read_cycles - rd0); end
    checks++; if (mem[4] !== m4) begin errors++; $display("FAIL errors_mem_unchanged: got %h want %h", mem[4], m4); end
  endtask

  task automatic test_store_rmw();
    logic [2:0]  f3 [4];
    logic [31:0] ad [4];
    logic [31:0] wd [4];
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    logic        rdy, er;
    int          lat, wr0;
    logic [31:0] rd;
    f3 = '{3'b000, 3'b001, 3'b001, 3'b000};
    ad = '{32'h01000013, 32'h01000014, 32'h01000016, 32'h01000010};
    wd = '{32'h12345677, 32'hDEADBEEF, 32'h0000CAFE, 32'h000000FF};
    ea = '{32'h01000010, 32'h01000014, 32'h01000014, 32'h01000010};
    ed = '{32'h7799AABB, 32'h1122BEEF, 32'hCAFEBEEF, 32'h7799AAFF};
    for (int i = 0; i < 4; i++) begin
      wr0 = write_cnt;
      do_req(1'b1, f3[i], ad[i], wd[i], rdy, lat, rd, er);
      checks++; if (lat != 3) begin errors++; $display("FAIL rmw%0d_latency: got %0d want 3", i, lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL rmw%0d_err: got %b want 0", i, er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmw%0d_rdata: got %h want 0", i, rd); end
      checks++; if (write_cnt - wr0 != 1) begin errors++; $display("FAIL rmw%0d_write_count: got %0d want 1", i, write_cnt - wr0); end
      checks++; if (last_waddr !== ea[i]) begin errors++; $display("FAIL rmw%0d_waddr: got %h want %h", i, last_waddr, ea[i]); end
      checks++; if (last_wdata !== ed[i]) begin errors++; $display("FAIL rmw%0d_wdata: got %h want %h", i, last_wdata, ed[i]); end
    end
    checks++; if (mem[4] !== 32'h7799AAFF) begin errors++; $display("FAIL rmw_mem4: got %h want 7799aaff", mem[4]); end
    checks++; if (mem[5] !== 32'hCAFEBEEF) begin errors++; $display("FAIL rmw_mem5: got %h want cafebeef", mem[5]); end
  endtask

  task automatic test_sw();
    logic        rdy, er;
    int          lat, wr0, rd0;
    logic [31:0] rd;
    wr0 = write_cnt; rd0 = read_cycles;
    do_req(1'b1, 3'b010, 32'h01000018, 32'hCAFEF00D, rdy, lat, rd, er);
    checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err: got %b want 0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata: got %h want 0", rd); end
    checks++; if (read_cycles != rd0) begin errors++; $display("FAIL sw_no_read: got %0d read cycles want 0", read_cycles - rd0); end
    checks++; if (write_cnt - wr0 != 1) begin errors++; $display("FAIL sw_write_count: got %0d want 1", write_cnt - wr0); end
    checks++; if (last_waddr !== 32'h01000018) begin errors++; $display("FAIL sw_waddr: got %h want 01000018", last_waddr); end
    checks++; if (last_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_wdata: got %h want cafef00d", last_wdata); end
    do_req(1'b0, 3'b010, 32'h01000018, 32'h0, rdy, lat, rd, er);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_readback: got %h want cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic        rdy, er;
    int          lat;
    logic [31:0] rd;
    do_req(1'b0, 3'b010, 32'h01000010, 32'h0, rdy, lat, rd, er);
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_resp: got %b want 0", req_ready_o); end
    do_req(1'b0, 3'b100, 32'h01000011, 32'h0, rdy, lat, rd, er);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_resp: got %b want 1", rdy); end
    checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL b2b_rdata: got %h want 000000aa", rd); end
    @(negedge clk);
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_resp_one_cycle: got %b want 0", resp_valid_o); end
  endtask

  task automatic test_timeout();
    logic        rdy, er;
    int          lat, wr0, rd0;
    logic [31:0] rd, m4;
    vld_en = 1'b0;
    wr0 = write_cnt; rd0 = read_cycles; m4 = mem[4];
    do_req(1'b0, 3'b010, 32'h01000010, 32'h0, rdy, lat, rd, er);
    checks++; if (lat != 16) begin errors++; $display("FAIL tmo_load_latency: got %0d want 16", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL tmo_load_err: got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tmo_load_rdata: got %h want 0", rd); end
    checks++; if (read_cycles - rd0 != 15) begin errors++; $display("FAIL tmo_wait_cycles: got %0d want 15", read_cycles - rd0); end
    do_req(1'b1, 3'b000, 32'h01000011, 32'h00000055, rdy, lat, rd, er);
    checks++; if (lat != 16) begin errors++; $display("FAIL tmo_rmw_latency: got %0d want 16", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL tmo_rmw_err: got %b want 1", er); end
    checks++; if (write_cnt != wr0) begin errors++; $display("FAIL tmo_no_write: got %0d writes want 0", write_cnt - wr0); end
    checks++; if (mem[4] !== m4) begin errors++; $display("FAIL tmo_mem_unchanged: got %h want %h", mem[4], m4); end
    vld_en = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int wr0;
    int seen;
    wr0 = write_cnt;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
    req_addr_i = 32'h0100001C; req_wdata_i = 32'h0BADF00D;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (mem_write_en_o !== 1'b1) begin errors++; $display("FAIL rstwr_in_wr: got %b want 1", mem_write_en_o); end
    #1 rst = 1'b0;
    #1;
    checks++; if (mem_write_en_o !== 1'b0) begin errors++; $display("FAIL rstwr_write_drop: got %b want 0", mem_write_en_o); end
    checks++; if (mem_data_o !== 32'h0) begin errors++; $display("FAIL rstwr_mem_data: got %h want 0", mem_data_o); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid_o === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstwr_no_resp: got %0d pulses want 0", seen); end
    checks++; if (write_cnt != wr0) begin errors++; $display("FAIL rstwr_no_write: got %0d writes want 0", write_cnt - wr0); end
    checks++; if (mem[7] !== 32'h55667788) begin errors++; $display("FAIL rstwr_mem_unchanged: got %h want 55667788", mem[7]); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rstwr_ready: got %b want 1", req_ready_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_loads();
    test_errors();
    test_store_rmw();
    test_sw();
    test_back_to_back();
    test_timeout();
    test_reset_mid_write();
    checks++; if (bad_overlap != 0) begin errors++; $display("FAIL enable_overlap: got %0d cycles want 0", bad_overlap); end
    checks++; if (bad_idle != 0) begin errors++; $display("FAIL enable_in_idle_resp: got %0d cycles want 0", bad_idle); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
